// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// ----------------
// Receive side of a multiplexed 7-segment display.
// It watches the segment and digit-select buses and waits until each digit's
// pattern has been steady for a set number of cycles. It then decodes the
// pattern back to a BCD digit. Once all six digits of HH:MM:SS have been
// captured, the whole time is published in a single cycle.
//
// Valid/ready note: there is no backpressure. frameValid and frameErr are
// single-cycle strobes. The time outputs are stable from the cycle frameValid
// is high until the next frameValid.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   segSel     segments, active-low, {dp,g,f,e,d,c,b,a}, asynchronous to clk
//   digSel     digit enables, active-low one-hot; bit0 = sec ones ...
//              bit5 = hour tens; bits 7:6 unused (must read 1)
//   secOnes, secTens, minOnes, minTens, hourOnes, hourTens
//              last published time (BCD)
//   frameValid one-cycle pulse: a new consistent time was published
//   frameErr   one-cycle pulse: a completed frame was discarded
//   stale      no frame published for TIMEOUT_CYC cycles
//   errCount   saturating count of frameErr pulses
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] segSel,
    input  logic [7:0] digSel,
    output logic [3:0] secOnes,
    output logic [2:0] secTens,
    output logic [3:0] minOnes,
    output logic [2:0] minTens,
    output logic [3:0] hourOnes,
    output logic [1:0] hourTens,
    output logic       frameValid,
    output logic       frameErr,
    output logic       stale,
    output logic [7:0] errCount
);

    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_PRE = TMR_W'(TIMEOUT_CYC - 1);

    // Input synchronizers. They reset to all-ones, the idle level of the bus.
    logic [7:0] segSync [SYNC_STAGES];
    logic [7:0] digSync [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                segSync[i] <= 8'hFF;
                digSync[i] <= 8'hFF;
            end
        end else begin
            segSync[0] <= segSel;
            digSync[0] <= digSel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                segSync[i] <= segSync[i-1];
                digSync[i] <= digSync[i-1];
            end
        end
    end

    logic [7:0] segS;
    logic [7:0] digS;
    assign segS = segSync[SYNC_STAGES-1];
    assign digS = digSync[SYNC_STAGES-1];

    // Digit-select qualification: exactly one active-low enable among the six
    // used lines, and both unused lines high.
    logic [5:0] lowSel;
    logic       digValid;
    assign lowSel   = ~digS[5:0];
    assign digValid = (digS[7:6] == 2'b11) && (lowSel != 6'd0) &&
                      ((lowSel & (lowSel - 6'd1)) == 6'd0);

    // Pattern decode. Only the seven segments count; dp is ignored.
    // The result is {bad, value}.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        logic [4:0] res;
        case ({1'b1, seg})
            8'hC0:   res = {1'b0, 4'd0};
            8'hF9:   res = {1'b0, 4'd1};
            8'hA4:   res = {1'b0, 4'd2};
            8'hB0:   res = {1'b0, 4'd3};
            8'h99:   res = {1'b0, 4'd4};
            8'h92:   res = {1'b0, 4'd5};
            8'h82:   res = {1'b0, 4'd6};
            8'hF8:   res = {1'b0, 4'd7};
            8'h80:   res = {1'b0, 4'd8};
            8'h90:   res = {1'b0, 4'd9};
            default: res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

    logic [15:0]      prevPair;
    logic [CNT_W-1:0] stabCnt;
    logic             armed;
    logic [3:0]       slotVal [6];
    logic [5:0]       seen;
    logic             codeErr;
    logic             completePend;
    logic [TMR_W-1:0] staleTmr;

    logic             pairChanged;
    logic [CNT_W-1:0] nextCnt;
    logic             nextArmed;
    logic             accept;
    logic [4:0]       dec;
    logic [5:0]       seenNext;
    logic             codeErrNext;
    logic             rangeOk;
    logic             publish;

    assign pairChanged = ({segS, digS} != prevPair);
    assign dec         = decodeSeg(segS[6:0]);

    // Stability tracking. A change of the pair, or an unusable digit
    // select, restarts the dwell. armed allows only one accept per dwell.
    always_comb begin
        nextCnt   = stabCnt;
        nextArmed = armed;
        if (pairChanged || !digValid) begin
            nextCnt   = '0;
            nextArmed = 1'b1;
        end else if (stabCnt != CNT_MAX) begin
            nextCnt = stabCnt + 1'b1;
        end
        accept = digValid && nextArmed && (nextCnt == CNT_MAX);
    end

    // The completion cycle starts a fresh frame. An accept that lands in
    // that same cycle already counts toward the next frame.
    always_comb begin
        seenNext    = completePend ? 6'd0 : seen;
        codeErrNext = completePend ? 1'b0 : codeErr;
        if (accept) begin
            seenNext    = seenNext | lowSel;
            codeErrNext = codeErrNext | dec[4];
        end
    end

    assign rangeOk = (slotVal[1] <= 4'd5) && (slotVal[3] <= 4'd5) &&
                     (slotVal[5] <= 4'd2) &&
                     !((slotVal[5] == 4'd2) && (slotVal[4] > 4'd3));
    assign publish = completePend && !codeErr && rangeOk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prevPair     <= 16'hFFFF;
            stabCnt      <= '0;
            armed        <= 1'b1;
            for (int i = 0; i < 6; i++) slotVal[i] <= 4'd0;
            seen         <= 6'd0;
            codeErr      <= 1'b0;
            completePend <= 1'b0;
            secOnes      <= 4'd0;
            secTens      <= 3'd0;
            minOnes      <= 4'd0;
            minTens      <= 3'd0;
            hourOnes     <= 4'd0;
            hourTens     <= 2'd0;
            frameValid   <= 1'b0;
            frameErr     <= 1'b0;
            stale        <= 1'b0;
            errCount     <= 8'd0;
            staleTmr     <= '0;
        end else begin
            prevPair     <= {segS, digS};
            stabCnt      <= nextCnt;
            armed        <= accept ? 1'b0 : nextArmed;
            seen         <= seenNext;
            codeErr      <= codeErrNext;
            completePend <= accept && (seenNext == 6'h3F);
            frameValid   <= 1'b0;
            frameErr     <= 1'b0;

            for (int i = 0; i < 6; i++) begin
                if (accept && lowSel[i]) slotVal[i] <= dec[3:0];
            end

            if (publish) begin
                secOnes    <= slotVal[0];
                secTens    <= slotVal[1][2:0];
                minOnes    <= slotVal[2];
                minTens    <= slotVal[3][2:0];
                hourOnes   <= slotVal[4];
                hourTens   <= slotVal[5][1:0];
                frameValid <= 1'b1;
            end else if (completePend) begin
                frameErr <= 1'b1;
                if (errCount != 8'hFF) errCount <= errCount + 8'd1;
            end

            // Only a published frame restarts the timeout. Discarded frames
            // do not prove the display path is healthy.
            if (publish) begin
                staleTmr <= '0;
                stale    <= 1'b0;
            end else begin
                if (staleTmr != TMR_MAX) staleTmr <= staleTmr + 1'b1;
                stale <= (staleTmr >= TMR_PRE);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder. It scans HH:MM:SS frames onto the segment
// and digit buses, and a scoreboard compares each published or discarded
// frame against a reference model of the display rules.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 2000;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] segSel = 8'hFF;
    logic [7:0] digSel = 8'hFF;
    logic [3:0] secOnes, minOnes, hourOnes;
    logic [2:0] secTens, minTens;
    logic [1:0] hourTens;
    logic       frameValid, frameErr, stale;
    logic [7:0] errCount;

    seg_scan_decoder #(
        .STABLE_CYC (STABLE),
        .TIMEOUT_CYC(TMO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .segSel    (segSel),
        .digSel    (digSel),
        .secOnes   (secOnes),
        .secTens   (secTens),
        .minOnes   (minOnes),
        .minTens   (minTens),
        .hourOnes  (hourOnes),
        .hourTens  (hourTens),
        .frameValid(frameValid),
        .frameErr  (frameErr),
        .stale     (stale),
        .errCount  (errCount)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #10 clk = ~clk;

    int unsigned cycCnt = 0;
    always @(posedge clk) cycCnt <= cycCnt + 1;

    // ---------------- reference data ----------------
    // Active-low segment patterns {g..a} for digits 0..9.
    logic [6:0] segTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [3:0] digv [6];   // digit values, index 0 = sec ones
    bit         badv [6];   // drive an undecodable pattern on that digit
    bit         dpv  [6];   // decimal point level; ignored by the decoder

    // Scoreboard entry: {isErr, hourTens, hourOnes, minTens, minOnes,
    // secTens, secOnes, errCount}
    logic [28:0] expQ [$];
    logic [19:0] lastTime = 20'd0;
    int          errExp = 0;
    int unsigned lastFv = 0;

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycCnt);
    endtask

    // ---------------- reference model ----------------
    // A frame is good when every digit decodes, seconds and minutes tens
    // are at most 5, and the hour is at most 23.
    task automatic modelFrame();
        bit anyBad;
        int hours;
        anyBad = 1'b0;
        for (int i = 0; i < 6; i++) if (badv[i]) anyBad = 1'b1;
        hours = int'(digv[5]) * 10 + int'(digv[4]);
        if (!anyBad && digv[1] <= 5 && digv[3] <= 5 && hours <= 23) begin
            lastTime = {digv[5][1:0], digv[4], digv[3][2:0], digv[2],
                        digv[1][2:0], digv[0]};
            expQ.push_back({1'b0, lastTime, 8'(errExp)});
        end else begin
            errExp = (errExp < 255) ? errExp + 1 : 255;
            expQ.push_back({1'b1, lastTime, 8'(errExp)});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic setTime(input int h, input int m, input int s);
        digv[5] = 4'(h / 10); digv[4] = 4'(h % 10);
        digv[3] = 4'(m / 10); digv[2] = 4'(m % 10);
        digv[1] = 4'(s / 10); digv[0] = 4'(s % 10);
        for (int i = 0; i < 6; i++) begin
            badv[i] = 1'b0;
            dpv[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic driveDigit(input int idx, input int dwell, input bit glitch);
        logic [7:0] one;
        one = 8'h01;
        @(negedge clk);
        digSel = ~(one << idx);
        if (glitch) begin
            segSel = 8'h80;
            repeat (2) @(negedge clk);
        end
        segSel = badv[idx] ? {dpv[idx], 7'h7F} : {dpv[idx], segTab[digv[idx]]};
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scanDigits(input int lo, input int hi, input bit glitch);
        for (int i = lo; i <= hi; i++) driveDigit(i, $urandom_range(10, 40), glitch);
    endtask

    task automatic scanFrame(input bit glitch);
        modelFrame();
        scanDigits(0, 5, glitch);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && expQ.size() != 0; k++) @(negedge clk);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "_secOnes"},  32'(secOnes),  32'd0);
        check({tag, "_secTens"},  32'(secTens),  32'd0);
        check({tag, "_minOnes"},  32'(minOnes),  32'd0);
        check({tag, "_minTens"},  32'(minTens),  32'd0);
        check({tag, "_hourOnes"}, 32'(hourOnes), 32'd0);
        check({tag, "_hourTens"}, 32'(hourTens), 32'd0);
        check({tag, "_pulses"},   32'({frameValid, frameErr}), 32'd0);
        check({tag, "_stale"},    32'(stale),    32'd0);
        check({tag, "_errCount"}, 32'(errCount), 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst && (frameValid || frameErr)) begin
            logic [28:0] e;
            check("pulse_exclusive", 32'(frameValid && frameErr), 32'd0);
            if (expQ.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpected_frame: got valid=%0b err=%0b expected no frame (cycle %0d)",
                         frameValid, frameErr, cycCnt);
            end else begin
                e = expQ.pop_front();
                check("frame", 32'({frameErr, hourTens, hourOnes, minTens, minOnes,
                                    secTens, secOnes, errCount}), 32'(e));
            end
            if (frameValid) begin
                check("stale_on_valid", 32'(stale), 32'd0);
                lastFv = cycCnt;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int target;

        repeat (5) @(negedge clk);
        checkCleared("reset");
        rst = 1'b1;

        // Clean repeated scans of 12:34:56.
        setTime(12, 34, 56);
        repeat (3) scanFrame(1'b0);

        // Same time with a short 0x80 glitch at each digit boundary.
        repeat (2) scanFrame(1'b1);

        // Blank pattern on minute ones: the frame is discarded and the
        // previous time is held. The clean scan that follows publishes.
        setTime(12, 34, 56);
        badv[2] = 1'b1;
        dpv[2]  = 1'b1;
        scanFrame(1'b0);
        setTime(12, 34, 56);
        scanFrame(1'b0);

        // Hour out of range.
        setTime(25, 0, 0);
        scanFrame(1'b0);

        // Two digits enabled at once for 100 cycles, in the middle of a frame.
        setTime(10, 20, 39);
        modelFrame();
        scanDigits(0, 2, 1'b0);
        @(negedge clk);
        digSel = 8'hFC;
        segSel = {1'b0, segTab[7]};
        repeat (100) @(negedge clk);
        scanDigits(3, 5, 1'b0);
        drain();

        // Stop scanning. stale must rise exactly TIMEOUT cycles after the
        // last publish.
        @(negedge clk);
        digSel = 8'hFF;
        segSel = 8'hFF;
        target = int'(lastFv) + TMO - 1;
        for (int k = 0; k < TMO + 100 && int'(cycCnt) < target; k++) @(negedge clk);
        check("stale_wait", cycCnt, 32'(target));
        check("stale_before_timeout", 32'(stale), 32'd0);
        @(negedge clk);
        check("stale_at_timeout", 32'(stale), 32'd1);
        repeat (50) @(negedge clk);
        check("stale_held", 32'(stale), 32'd1);
        setTime(9, 41, 7);
        scanFrame(1'b0);
        drain();
        check("stale_after_resume", 32'(stale), 32'd0);

        // Random frames: mostly legal times, some fully random digits, and
        // some with an undecodable digit.
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) != 0)
                setTime($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            else begin
                setTime(0, 0, 0);
                for (int i = 0; i < 6; i++) digv[i] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 6) == 0) badv[$urandom_range(0, 5)] = 1'b1;
            scanFrame(1'($urandom_range(0, 1)));
        end
        drain();

        // Reset after three digits of a frame. The partial frame must vanish
        // without a pulse, and a full 00:00:59 scan then publishes.
        setTime(13, 57, 42);
        scanDigits(0, 2, 1'b0);
        @(negedge clk);
        digSel = 8'hFF;
        segSel = 8'hFF;
        rst    = 1'b0;
        repeat (3) @(negedge clk);
        checkCleared("midreset");
        errExp   = 0;
        lastTime = 20'd0;
        rst      = 1'b1;
        setTime(0, 0, 59);
        scanFrame(1'b0);
        drain();
        repeat (20) @(negedge clk);

        check("queue_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
